// File: rtl/commit_buffer.sv
// rtl/commit_buffer.sv - in-order retire buffer with forwarding lookup, trap detect and counters
module commit_buffer #(
  parameter int DEPTH = 8,
  parameter int RET_W = 2,
  parameter int NRD   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [63:0]         in_pc,
  input  logic [31:0]         in_instr,
  input  logic                in_wen,
  input  logic [4:0]          in_wdest,
  input  logic [63:0]         in_wdata,
  input  logic                in_skip,
  input  logic                drain,
  output logic [RET_W-1:0]    ret_valid,
  output logic [RET_W*64-1:0] ret_pc,
  output logic [RET_W*32-1:0] ret_instr,
  output logic [RET_W-1:0]    ret_wen,
  output logic [RET_W*5-1:0]  ret_wdest,
  output logic [RET_W*64-1:0] ret_wdata,
  output logic [RET_W-1:0]    ret_skip,
  input  logic [NRD*5-1:0]    q_addr,
  output logic [NRD-1:0]      q_hit,
  output logic [NRD*64-1:0]   q_data,
  output logic                trap_valid,
  output logic [2:0]          trap_code,
  output logic [63:0]         trap_pc,
  output logic [63:0]         cycle_cnt,
  output logic [63:0]         instr_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] TRAP_INSTR = 32'h0005006b;

  logic [63:0] pc_q    [DEPTH];
  logic [31:0] instr_q [DEPTH];
  logic        wen_q   [DEPTH];
  logic [4:0]  wdest_q [DEPTH];
  logic [63:0] wdata_q [DEPTH];
  logic        skip_q  [DEPTH];

  logic [AW-1:0] head, tail;
  logic [AW:0]   count;
  logic          halted;
  logic          enq;
  logic          blocked;
  logic [AW:0]   nret;
  logic [AW-1:0] ent_idx [DEPTH];
  logic [DEPTH-1:0] ent_live;

  assign in_ready = (count < (AW+1)'(DEPTH)) && !halted && reset;
  assign enq      = in_valid && in_ready && !flush;

  // ent_idx[j] is the slot of the j-th oldest entry; ent_live marks it occupied
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      ent_idx[j]  = head + AW'(j);
      ent_live[j] = (AW+1)'(j) < count;
    end
  end

  // A retiring trap blocks every younger lane in the same cycle
  always_comb begin
    blocked    = 1'b0;
    nret       = '0;
    ret_valid  = '0;
    ret_pc     = '0;
    ret_instr  = '0;
    ret_wen    = '0;
    ret_wdest  = '0;
    ret_wdata  = '0;
    ret_skip   = '0;
    trap_valid = 1'b0;
    trap_code  = '0;
    trap_pc    = '0;
    for (int i = 0; i < RET_W; i++) begin
      ret_valid[i] = drain && !flush && !halted && !blocked && ent_live[i];
      if (ret_valid[i]) begin
        nret                 = nret + (AW+1)'(1);
        ret_pc[64*i +: 64]   = pc_q[ent_idx[i]];
        ret_instr[32*i +: 32] = instr_q[ent_idx[i]];
        ret_wen[i]           = wen_q[ent_idx[i]] && (wdest_q[ent_idx[i]] != 5'd0);
        ret_wdest[5*i +: 5]  = wdest_q[ent_idx[i]];
        ret_wdata[64*i +: 64] = wdata_q[ent_idx[i]];
        ret_skip[i]          = skip_q[ent_idx[i]];
        if (instr_q[ent_idx[i]] == TRAP_INSTR) begin
          trap_valid = 1'b1;
          trap_code  = wdata_q[ent_idx[i]][2:0];
          trap_pc    = pc_q[ent_idx[i]];
          blocked    = 1'b1;
        end
      end
    end
  end

  // Scan oldest to youngest so the youngest match is the one left standing
  always_comb begin
    q_hit  = '0;
    q_data = '0;
    for (int k = 0; k < NRD; k++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (ent_live[j] && wen_q[ent_idx[j]] && (q_addr[5*k +: 5] != 5'd0) &&
            (wdest_q[ent_idx[j]] == q_addr[5*k +: 5])) begin
          q_hit[k]           = 1'b1;
          q_data[64*k +: 64] = wdata_q[ent_idx[j]];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      pc_q[tail]    <= in_pc;
      instr_q[tail] <= in_instr;
      wen_q[tail]   <= in_wen;
      wdest_q[tail] <= in_wdest;
      wdata_q[tail] <= in_wdata;
      skip_q[tail]  <= in_skip;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      halted    <= 1'b0;
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
      instr_cnt <= instr_cnt + 64'(nret);
      if (trap_valid) halted <= 1'b1;
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        head  <= head + nret[AW-1:0];
        if (enq) tail <= tail + AW'(1);
        count <= count + (AW+1)'(enq) - nret;
      end
    end
  end
endmodule

// File: tb/tb_commit_buffer.sv
// tb/tb_commit_buffer.sv - randomized and directed bench for commit_buffer against a queue model
module tb_commit_buffer;
  localparam int DEPTH = 8;
  localparam int RET_W = 2;
  localparam int NRD = 2;
  localparam logic [31:0] TRAP = 32'h0005006b;

  logic clk, reset, flush, in_valid, in_ready, in_wen, in_skip, drain;
  logic [63:0] in_pc, in_wdata;
  logic [31:0] in_instr;
  logic [4:0] in_wdest;
  logic [RET_W-1:0] ret_valid, ret_wen, ret_skip;
  logic [RET_W*64-1:0] ret_pc, ret_wdata;
  logic [RET_W*32-1:0] ret_instr;
  logic [RET_W*5-1:0] ret_wdest;
  logic [NRD*5-1:0] q_addr;
  logic [NRD-1:0] q_hit;
  logic [NRD*64-1:0] q_data;
  logic trap_valid;
  logic [2:0] trap_code;
  logic [63:0] trap_pc, cycle_cnt, instr_cnt;

  commit_buffer #(.DEPTH(DEPTH), .RET_W(RET_W), .NRD(NRD)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_wen(in_wen), .in_wdest(in_wdest),
    .in_wdata(in_wdata), .in_skip(in_skip), .drain(drain), .ret_valid(ret_valid),
    .ret_pc(ret_pc), .ret_instr(ret_instr), .ret_wen(ret_wen), .ret_wdest(ret_wdest),
    .ret_wdata(ret_wdata), .ret_skip(ret_skip), .q_addr(q_addr), .q_hit(q_hit),
    .q_data(q_data), .trap_valid(trap_valid), .trap_code(trap_code), .trap_pc(trap_pc),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        wen;
    logic [4:0]  wdest;
    logic [63:0] wdata;
    logic        skip;
  } ent_t;

  ent_t mq[$];
  bit mhalt;
  logic [63:0] mcyc, minstr;
  int n_cmp = 0;
  int n_bad = 0;

  logic [RET_W-1:0] e_valid, e_wenv;
  logic [RET_W*64-1:0] e_pcv, e_wdatav;
  logic e_trap, exp_ready;
  logic [2:0] e_code;
  logic [63:0] e_tpc;

  function automatic void compute_exp();
    e_valid = '0; e_wenv = '0; e_pcv = '0; e_wdatav = '0;
    e_trap = 1'b0; e_code = '0; e_tpc = '0;
    exp_ready = reset && (mq.size() < DEPTH) && !mhalt;
    if (drain && !flush && !mhalt) begin
      for (int i = 0; i < RET_W && i < mq.size(); i++) begin
        e_valid[i] = 1'b1;
        e_pcv[64*i +: 64] = mq[i].pc;
        e_wenv[i] = mq[i].wen && (mq[i].wdest != 5'd0);
        e_wdatav[64*i +: 64] = mq[i].wdata;
        if (mq[i].instr == TRAP) begin
          e_trap = 1'b1; e_code = mq[i].wdata[2:0]; e_tpc = mq[i].pc;
          break;
        end
      end
    end
  endfunction

  function automatic logic [64:0] model_lookup(logic [4:0] a);
    if (a == 5'd0) return '0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].wen && mq[i].wdest == a) return {1'b1, mq[i].wdata};
    return '0;
  endfunction

  task automatic tick();
    int n;
    bit rdy, trp;
    compute_exp();
    rdy = exp_ready; n = $countones(e_valid); trp = e_trap;
    @(posedge clk);
    if (!reset) begin
      mq.delete(); mhalt = 0; mcyc = '0; minstr = '0;
    end else begin
      mcyc = mcyc + 64'd1;
      if (flush) mq.delete();
      else begin
        for (int i = 0; i < n; i++) void'(mq.pop_front());
        minstr = minstr + 64'(n);
        if (trp) mhalt = 1;
        if (in_valid && rdy)
          mq.push_back('{pc: in_pc, instr: in_instr, wen: in_wen, wdest: in_wdest,
                         wdata: in_wdata, skip: in_skip});
      end
    end
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_in(logic [63:0] pc, logic [31:0] ins, logic w, logic [4:0] d, logic [63:0] dat);
    in_valid = 1'b1; in_pc = pc; in_instr = ins; in_wen = w; in_wdest = d; in_wdata = dat;
    in_skip = 1'($urandom_range(0, 1));
  endtask

  task automatic drain_empty();
    in_valid = 1'b0; flush = 1'b0; drain = 1'b1;
    for (int c = 0; c < 20 && mq.size() > 0; c++) tick();
    drain = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 0; in_valid = 0; drain = 0; q_addr = '0;
    in_pc = '0; in_instr = '0; in_wen = 0; in_wdest = '0; in_wdata = '0; in_skip = 0;
    mq.delete(); mhalt = 0; mcyc = '0; minstr = '0;
    tick(); tick(); settle();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    n_cmp++; if (ret_valid !== '0) begin n_bad++; $display("FAIL rst_ret_valid got %b exp 0", ret_valid); end
    n_cmp++; if (cycle_cnt !== 64'd0) begin n_bad++; $display("FAIL rst_cycle_cnt got %0d exp 0", cycle_cnt); end
    n_cmp++; if (instr_cnt !== 64'd0) begin n_bad++; $display("FAIL rst_instr_cnt got %0d exp 0", instr_cnt); end
    n_cmp++; if (trap_valid !== 1'b0) begin n_bad++; $display("FAIL rst_trap got %b exp 0", trap_valid); end
    reset = 1'b1;
    tick(); settle();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rel_in_ready got %b exp 1", in_ready); end
    n_cmp++; if (cycle_cnt !== 64'd1) begin n_bad++; $display("FAIL rel_cycle_cnt got %0d exp 1", cycle_cnt); end
  endtask

  task automatic test_fill();
    drain = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_in(64'h1000 + 64'(4*i), 32'h00000013, 1'b1, 5'(i+1), {$urandom, $urandom});
      settle();
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL fill_ready[%0d] got %b exp 1", i, in_ready); end
      tick();
    end
    set_in(64'h2000, 32'h00000013, 1'b1, 5'd3, 64'h99);
    settle();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready got %b exp 0", in_ready); end
    n_cmp++; if (ret_valid !== 2'b00) begin n_bad++; $display("FAIL nodrain_valid got %b exp 00", ret_valid); end
    tick();
    in_valid = 1'b0; drain = 1'b1;
    for (int c = 0; c < 4; c++) begin
      settle();
      n_cmp++; if (ret_valid !== 2'b11) begin n_bad++; $display("FAIL fill_ret_valid[%0d] got %b exp 11", c, ret_valid); end
      n_cmp++;
      if (ret_pc !== {64'h1000 + 64'(8*c + 4), 64'h1000 + 64'(8*c)}) begin
        n_bad++; $display("FAIL fill_ret_pc[%0d] got %h exp %h_%h", c, ret_pc, 64'h1000 + 64'(8*c + 4), 64'h1000 + 64'(8*c));
      end
      tick();
    end
    settle();
    n_cmp++; if (ret_valid !== 2'b00) begin n_bad++; $display("FAIL fill_empty got %b exp 00", ret_valid); end
    n_cmp++; if (instr_cnt !== 64'd8) begin n_bad++; $display("FAIL fill_instr_cnt got %0d exp 8", instr_cnt); end
    drain = 1'b0;
  endtask

  task automatic test_wrap();
    int acc = 0;
    for (int cyc = 0; cyc < 100 && acc < 20; cyc++) begin
      set_in(64'h3000 + 64'(4*acc), 32'h00000013, 1'b1, 5'(acc % 31 + 1), 64'(acc));
      drain = 1'(cyc % 2);
      settle(); compute_exp();
      n_cmp++; if (in_ready !== exp_ready) begin n_bad++; $display("FAIL wrap_ready[%0d] got %b exp %b", cyc, in_ready, exp_ready); end
      n_cmp++; if (ret_valid !== e_valid) begin n_bad++; $display("FAIL wrap_valid[%0d] got %b exp %b", cyc, ret_valid, e_valid); end
      n_cmp++; if (ret_pc !== e_pcv) begin n_bad++; $display("FAIL wrap_pc[%0d] got %h exp %h", cyc, ret_pc, e_pcv); end
      if (exp_ready) acc++;
      tick();
    end
    n_cmp++; if (acc != 20) begin n_bad++; $display("FAIL wrap_accepted got %0d exp 20", acc); end
    drain_empty();
  endtask

  task automatic test_forward();
    drain = 1'b0;
    set_in(64'h4000, 32'h00000013, 1'b1, 5'd5, 64'h11); tick();
    set_in(64'h4004, 32'h00000013, 1'b1, 5'd5, 64'h22); tick();
    set_in(64'h4008, 32'h00000013, 1'b1, 5'd0, 64'h33); tick();
    in_valid = 1'b0;
    q_addr = {5'd0, 5'd5};
    settle();
    n_cmp++; if (q_hit !== 2'b01) begin n_bad++; $display("FAIL fwd_hit got %b exp 01", q_hit); end
    n_cmp++; if (q_data[63:0] !== 64'h22) begin n_bad++; $display("FAIL fwd_data got %h exp 22", q_data[63:0]); end
    n_cmp++; if (q_data[127:64] !== 64'h0) begin n_bad++; $display("FAIL fwd_x0_data got %h exp 0", q_data[127:64]); end
    drain = 1'b1;
    settle();
    n_cmp++; if (ret_wen !== 2'b11) begin n_bad++; $display("FAIL fwd_ret_wen got %b exp 11", ret_wen); end
    n_cmp++; if (ret_wdata !== {64'h22, 64'h11}) begin n_bad++; $display("FAIL fwd_ret_wdata got %h", ret_wdata); end
    n_cmp++; if (q_hit[0] !== 1'b1 || q_data[63:0] !== 64'h22) begin n_bad++; $display("FAIL fwd_retiring got %b/%h exp 1/22", q_hit[0], q_data[63:0]); end
    tick(); settle();
    n_cmp++; if (ret_valid !== 2'b01 || ret_wen !== 2'b00) begin n_bad++; $display("FAIL fwd_x0_wen got v%b w%b exp v01 w00", ret_valid, ret_wen); end
    tick();
    drain = 1'b0;
  endtask

  task automatic test_flush();
    drain = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_in(64'h5000 + 64'(4*i), 32'h00000013, 1'b1, 5'd9, 64'(i + 100)); tick();
    end
    set_in(64'h5555, 32'h00000013, 1'b1, 5'd9, 64'h5555);
    flush = 1'b1; drain = 1'b1; q_addr = {5'd0, 5'd9};
    tick();
    flush = 1'b0; in_valid = 1'b0;
    settle();
    n_cmp++; if (ret_valid !== 2'b00) begin n_bad++; $display("FAIL flush_valid got %b exp 00", ret_valid); end
    n_cmp++; if (q_hit !== 2'b00) begin n_bad++; $display("FAIL flush_hit got %b exp 00", q_hit); end
    n_cmp++; if (instr_cnt !== minstr) begin n_bad++; $display("FAIL flush_instr_cnt got %0d exp %0d", instr_cnt, minstr); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_ready got %b exp 1", in_ready); end
    drain = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [64:0] lk;
    for (int cyc = 0; cyc < 300; cyc++) begin
      r = $urandom;
      if (r == TRAP) r = r ^ 32'h1;
      set_in({$urandom, $urandom}, r, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom});
      in_valid = 1'($urandom_range(0, 1));
      drain = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 39) == 0);
      q_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      settle(); compute_exp();
      n_cmp++; if (in_ready !== exp_ready) begin n_bad++; $display("FAIL rnd_ready[%0d] got %b exp %b", cyc, in_ready, exp_ready); end
      n_cmp++; if (ret_valid !== e_valid) begin n_bad++; $display("FAIL rnd_valid[%0d] got %b exp %b", cyc, ret_valid, e_valid); end
      n_cmp++; if (ret_pc !== e_pcv) begin n_bad++; $display("FAIL rnd_pc[%0d] got %h exp %h", cyc, ret_pc, e_pcv); end
      n_cmp++; if (ret_wen !== e_wenv) begin n_bad++; $display("FAIL rnd_wen[%0d] got %b exp %b", cyc, ret_wen, e_wenv); end
      n_cmp++; if (ret_wdata !== e_wdatav) begin n_bad++; $display("FAIL rnd_wdata[%0d] got %h exp %h", cyc, ret_wdata, e_wdatav); end
      n_cmp++; if (trap_valid !== 1'b0) begin n_bad++; $display("FAIL rnd_trap[%0d] got %b exp 0", cyc, trap_valid); end
      for (int k = 0; k < NRD; k++) begin
        lk = model_lookup(q_addr[5*k +: 5]);
        n_cmp++;
        if (q_hit[k] !== lk[64] || q_data[64*k +: 64] !== lk[63:0]) begin
          n_bad++; $display("FAIL rnd_lookup[%0d][%0d] got %b/%h exp %b/%h", cyc, k, q_hit[k], q_data[64*k +: 64], lk[64], lk[63:0]);
        end
      end
      n_cmp++; if (instr_cnt !== minstr) begin n_bad++; $display("FAIL rnd_instr_cnt[%0d] got %0d exp %0d", cyc, instr_cnt, minstr); end
      n_cmp++; if (cycle_cnt !== mcyc) begin n_bad++; $display("FAIL rnd_cycle_cnt[%0d] got %0d exp %0d", cyc, cycle_cnt, mcyc); end
      tick();
    end
    flush = 1'b0;
    drain_empty();
  endtask

  task automatic test_trap();
    drain = 1'b0;
    set_in(64'h8000, TRAP, 1'b0, 5'd0, 64'h0); tick();
    set_in(64'h8004, 32'h00100093, 1'b1, 5'd1, 64'h77); tick();
    in_valid = 1'b0; drain = 1'b1;
    settle();
    n_cmp++; if (trap_valid !== 1'b1) begin n_bad++; $display("FAIL trap_valid got %b exp 1", trap_valid); end
    n_cmp++; if (trap_code !== 3'd0) begin n_bad++; $display("FAIL trap_code got %0d exp 0", trap_code); end
    n_cmp++; if (trap_pc !== 64'h8000) begin n_bad++; $display("FAIL trap_pc got %h exp 8000", trap_pc); end
    n_cmp++; if (ret_valid !== 2'b01) begin n_bad++; $display("FAIL trap_lanes got %b exp 01", ret_valid); end
    tick();
    set_in(64'h8008, 32'h00000013, 1'b1, 5'd2, 64'h1);
    settle();
    n_cmp++; if (trap_valid !== 1'b0) begin n_bad++; $display("FAIL trap_pulse got %b exp 0", trap_valid); end
    n_cmp++; if (ret_valid !== 2'b00) begin n_bad++; $display("FAIL trap_halt_valid got %b exp 00", ret_valid); end
    n_cmp++; if (instr_cnt !== minstr) begin n_bad++; $display("FAIL trap_instr_cnt got %0d exp %0d", instr_cnt, minstr); end
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL trap_ready[%0d] got %b exp 0", c, in_ready); end
      tick(); settle();
    end
    in_valid = 1'b0; drain = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    reset = 1'b0; tick(); reset = 1'b1; tick();
    drain = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_in(64'h9000 + 64'(4*i), 32'h00000013, 1'b1, 5'd4, 64'(i)); tick();
    end
    in_valid = 1'b0; drain = 1'b1;
    tick();
    reset = 1'b0;
    tick(); settle();
    n_cmp++; if (ret_valid !== 2'b00) begin n_bad++; $display("FAIL mid_rst_valid got %b exp 00", ret_valid); end
    n_cmp++; if (cycle_cnt !== 64'd0) begin n_bad++; $display("FAIL mid_rst_cycle got %0d exp 0", cycle_cnt); end
    n_cmp++; if (instr_cnt !== 64'd0) begin n_bad++; $display("FAIL mid_rst_instr got %0d exp 0", instr_cnt); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ready got %b exp 0", in_ready); end
    reset = 1'b1;
    tick(); settle();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rel_ready got %b exp 1", in_ready); end
    n_cmp++; if (ret_valid !== 2'b00) begin n_bad++; $display("FAIL mid_rel_valid got %b exp 00", ret_valid); end
    drain = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fill();
    test_wrap();
    test_forward();
    test_flush();
    test_random();
    test_trap();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
